// File: rtl/ntt_pkg.sv
// Shared types and helpers for the mixed radix-2/4 NTT stage/address controller.
package ntt_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_READ  = S_READ,
        ST_DRAIN = S_DRAIN,
        ST_DONE  = S_DONE
    } state_e;

    localparam logic        MODE_NTT  = 1'b0;
    localparam logic        MODE_INTT = 1'b1;
    localparam int unsigned NUM_BANKS = 4;

    // Bank of element j: sum of its base-4 digits, mod 4.
    function automatic logic [1:0] bank_of(input logic [31:0] j);
        logic [1:0] s;
        s = '0;
        for (int unsigned d = 0; d < 16; d++) begin
            s = s + j[2*d +: 2];
        end
        return s;
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Reset-flushed shift register carrying write-path valid/address/rotation.
module ntt_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (i_en) begin
            r_pipe[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/ntt_mixed_ctrl.sv
// Stage/address controller for the mixed radix-2/4 NTT over four banks.
// Optional NTT_MIXED_CTRL_STALL_EN adds i_stall, which freezes the whole schedule.
module ntt_mixed_ctrl
    import ntt_pkg::*;
#(
    parameter  int unsigned LOGN     = 8,
    parameter  int unsigned PIPE_LAT = 6,
    localparam int unsigned ADDR_W   = LOGN - 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_mode,
`ifdef NTT_MIXED_CTRL_STALL_EN
    input  logic                  i_stall,
`endif
    output logic                  o_rd_en,
    output logic [4*ADDR_W-1:0]   o_rd_addr,
    output logic [1:0]            o_rd_rot,
    output logic                  o_wr_en,
    output logic [4*ADDR_W-1:0]   o_wr_addr,
    output logic [1:0]            o_wr_rot,
    output logic [LOGN-1:0]       o_tw_addr,
    output logic                  o_radix4,
    output logic [3:0]            o_stage,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned CW   = LOGN - 2;
    localparam int unsigned S4   = LOGN / 2;
    localparam int unsigned ODD  = LOGN % 2;
    localparam int unsigned NSTG = S4 + ODD;
    localparam int unsigned DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int unsigned DLW  = 1 + 4*ADDR_W + 2;

    localparam logic [CW-1:0] C_LAST   = '1;
    localparam logic [3:0]    STG_LAST = 4'(NSTG - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(PIPE_LAT - 1);

    state_e          r_state;
    logic [CW-1:0]   r_c;
    logic [DW-1:0]   r_d;
    logic [3:0]      r_stage;
    logic            r_mode;

    logic            w_stall;
    logic            w_rd_en;
    logic            w_busy;
    logic            w_r2;
    logic [3:0]      w_p;
    logic [LOGN-1:0] w_mask;
    logic [LOGN-1:0] w_cx;
    logic [LOGN-1:0] w_j [4];
    logic [4*ADDR_W-1:0] w_rd_addr;
    logic [LOGN-1:0] w_tw;
    logic            w_wr_v;

`ifdef NTT_MIXED_CTRL_STALL_EN
    assign w_stall = i_stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_busy  = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign w_rd_en = (r_state == ST_READ) && !w_stall;

    // NTT runs the radix-2 stage first and digits high-to-low; INTT is the mirror image.
    always_comb begin
        w_r2 = 1'b0;
        w_p  = '0;
        if (r_mode == MODE_NTT) begin
            if (ODD != 0 && r_stage == 4'd0) w_r2 = 1'b1;
            else                             w_p  = 4'(S4 - 1 + ODD) - r_stage;
        end else begin
            if (ODD != 0 && r_stage == 4'(S4)) w_r2 = 1'b1;
            else                               w_p  = r_stage;
        end
    end

    always_comb begin
        w_cx      = LOGN'(r_c);
        w_mask    = (LOGN'(1) << (2*w_p)) - LOGN'(1);
        w_rd_addr = '0;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            if (w_r2) w_j[k] = {k[1], r_c[CW-1:1], k[0], r_c[0]};
            else      w_j[k] = ((w_cx & ~w_mask) << 2) | (LOGN'(k) << (2*w_p)) | (w_cx & w_mask);
        end
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            w_rd_addr[bank_of(32'(w_j[k]))*ADDR_W +: ADDR_W] = w_j[k][LOGN-1:2];
        end
        if (w_r2) w_tw = LOGN'(r_c);
        else      w_tw = LOGN'((32'(w_p) << (2*w_p)) | (32'(r_c) & ((32'd1 << (2*w_p)) - 32'd1)));
    end

    assign o_rd_en   = w_rd_en;
    assign o_rd_addr = w_rd_en ? w_rd_addr : '0;
    assign o_rd_rot  = w_rd_en ? bank_of(32'(w_j[0])) : 2'd0;
    assign o_tw_addr = w_rd_en ? w_tw : '0;
    assign o_radix4  = w_busy && !w_r2;
    assign o_stage   = r_stage;
    assign o_busy    = w_busy;
    assign o_done    = (r_state == ST_DONE);

    ntt_delay_line #(
        .WIDTH (DLW),
        .DEPTH (PIPE_LAT)
    ) u_wr_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (!w_stall),
        .i_data  ({o_rd_en, o_rd_addr, o_rd_rot}),
        .o_data  ({w_wr_v, o_wr_addr, o_wr_rot})
    );

    assign o_wr_en = w_wr_v && !w_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_stage <= '0;
            r_mode  <= MODE_NTT;
        end else if (!w_stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_READ;
                        r_mode  <= i_mode;
                        r_c     <= '0;
                        r_stage <= '0;
                    end
                end
                ST_READ: begin
                    r_c <= r_c + 1'b1;
                    if (r_c == C_LAST) begin
                        r_state <= ST_DRAIN;
                        r_d     <= '0;
                    end
                end
                ST_DRAIN: begin
                    r_d <= r_d + 1'b1;
                    if (r_d == D_LAST) begin
                        if (r_stage == STG_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_stage <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_mixed_ctrl.sv
// Self-checking bench for ntt_mixed_ctrl (LOGN=8 and LOGN=5 instances) against an arithmetic schedule model.
module tb_ntt_mixed_ctrl;

    localparam int P8 = 6;
    localparam int Q8 = 64;
    localparam int S8 = 4;
    localparam int L8 = Q8 + P8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        start8 = 1'b0, mode8 = 1'b0;
    logic        rd_en8, wr_en8, radix48, busy8, done8;
    logic [23:0] rd_addr8, wr_addr8;
    logic [1:0]  rd_rot8, wr_rot8;
    logic [7:0]  tw8;
    logic [3:0]  stage8;

    logic        start5 = 1'b0, mode5 = 1'b0;
    logic        rd_en5, wr_en5, radix45, busy5, done5;
    logic [11:0] rd_addr5, wr_addr5;
    logic [1:0]  rd_rot5, wr_rot5;
    logic [4:0]  tw5;
    logic [3:0]  stage5;

`ifdef NTT_MIXED_CTRL_STALL_EN
    logic stall = 1'b0;
`endif

    ntt_mixed_ctrl #(.LOGN(8), .PIPE_LAT(6)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_mode(mode8),
`ifdef NTT_MIXED_CTRL_STALL_EN
        .i_stall(stall),
`endif
        .o_rd_en(rd_en8), .o_rd_addr(rd_addr8), .o_rd_rot(rd_rot8),
        .o_wr_en(wr_en8), .o_wr_addr(wr_addr8), .o_wr_rot(wr_rot8),
        .o_tw_addr(tw8), .o_radix4(radix48), .o_stage(stage8),
        .o_busy(busy8), .o_done(done8)
    );

    ntt_mixed_ctrl #(.LOGN(5), .PIPE_LAT(6)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start5), .i_mode(mode5),
`ifdef NTT_MIXED_CTRL_STALL_EN
        .i_stall(stall),
`endif
        .o_rd_en(rd_en5), .o_rd_addr(rd_addr5), .o_rd_rot(rd_rot5),
        .o_wr_en(wr_en5), .o_wr_addr(wr_addr5), .o_wr_rot(wr_rot5),
        .o_tw_addr(tw5), .o_radix4(radix45), .o_stage(stage5),
        .o_busy(busy5), .o_done(done5)
    );

    // Reference model: plain arithmetic on element indices.
    function automatic int bankf(input int j);
        int s = 0;
        int v = j;
        while (v > 0) begin
            s = s + v % 4;
            v = v / 4;
        end
        return s % 4;
    endfunction

    // Digit position of a stage, or -1 for the radix-2 stage.
    function automatic int plan_p(input int logn, input int mode, input int s);
        int s4 = logn / 2;
        int odd = logn % 2;
        if (mode == 0) begin
            if (odd == 1 && s == 0) return -1;
            return s4 - 1 - (s - odd);
        end
        if (s < s4) return s;
        return -1;
    endfunction

    function automatic int elem(input int logn, input int p, input int c, input int k);
        int w;
        if (p < 0) return (k / 2) * (1 << (logn - 1)) + (c / 2) * 4 + (k % 2) * 2 + c % 2;
        w = 1 << (2 * p);
        return (c / w) * (w * 4) + k * w + c % w;
    endfunction

    function automatic int twf(input int logn, input int p, input int c);
        int w;
        if (p < 0) return c;
        w = 1 << (2 * p);
        return (p * w + c % w) % (1 << logn);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_en8, rd_addr8, rd_rot8, wr_en8, wr_addr8, wr_rot8, tw8, radix48, stage8, busy8, done8} !== '0) begin
            errors++;
            $display("FAIL reset8: outputs=%h required all zero",
                {rd_en8, rd_addr8, rd_rot8, wr_en8, wr_addr8, wr_rot8, tw8, radix48, stage8, busy8, done8});
        end
        checks++;
        if ({rd_en5, rd_addr5, rd_rot5, wr_en5, wr_addr5, wr_rot5, tw5, radix45, stage5, busy5, done5} !== '0) begin
            errors++;
            $display("FAIL reset5: outputs=%h required all zero",
                {rd_en5, rd_addr5, rd_rot5, wr_en5, wr_addr5, wr_rot5, tw5, radix45, stage5, busy5, done5});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_schedule8();
        logic [23:0]  h_addr [0:320];
        logic         h_en   [0:320];
        logic [1:0]   h_rot  [0:320];
        logic [255:0] seen;
        int           dup;
        int           idx, s, off, p, j, nset;
        logic         e_rd, e_busy, e_done, e_r4, e_wen;
        logic [3:0]   e_stage;
        logic [23:0]  e_addr, e_waddr;
        logic [1:0]   e_rot, e_wrot;
        logic [7:0]   e_tw;
        for (int m = 0; m < 2; m++) begin
            seen = '0;
            dup  = 0;
            @(posedge clk);
            #1;
            mode8  = 1'(m);
            start8 = 1'b1;
            for (int n = 1; n <= S8 * L8 + 4; n++) begin
                @(posedge clk);
                #1;
                if (n == 1) start8 = 1'b0;
                if (m == 1) begin
                    start8 = (n == 100) ? 1'b1 : 1'b0;
                    mode8  = 1'(n % 2);
                end
                idx    = n - 1;
                s      = idx / L8;
                off    = idx % L8;
                e_rd   = (s < S8) && (off < Q8);
                e_busy = (n <= S8 * L8);
                e_done = (n == S8 * L8 + 1);
                e_stage = (n <= S8 * L8) ? 4'(s) : (e_done ? 4'(S8 - 1) : 4'd0);
                p      = plan_p(8, m, (s < S8) ? s : S8 - 1);
                e_r4   = e_busy && (p >= 0);
                e_addr = '0;
                e_rot  = '0;
                e_tw   = '0;
                if (e_rd) begin
                    for (int k = 0; k < 4; k++) begin
                        j = elem(8, p, off, k);
                        e_addr[bankf(j) * 6 +: 6] = 6'(j / 4);
                    end
                    e_rot = 2'(bankf(elem(8, p, off, 0)));
                    e_tw  = 8'(twf(8, p, off));
                end
                h_en[n]   = e_rd;
                h_addr[n] = e_addr;
                h_rot[n]  = e_rot;
                e_wen   = (n > P8) ? h_en[n - P8]   : 1'b0;
                e_waddr = (n > P8) ? h_addr[n - P8] : '0;
                e_wrot  = (n > P8) ? h_rot[n - P8]  : '0;

                checks++;
                if ({rd_en8, busy8, done8, stage8, radix48} !== {e_rd, e_busy, e_done, e_stage, e_r4}) begin
                    errors++;
                    $display("FAIL ctl8 m=%0d n=%0d: rd/busy/done/stage/r4=%b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                        m, n, rd_en8, busy8, done8, stage8, radix48, e_rd, e_busy, e_done, e_stage, e_r4);
                end
                checks++;
                if ({rd_addr8, rd_rot8, tw8} !== {e_addr, e_rot, e_tw}) begin
                    errors++;
                    $display("FAIL rd8 m=%0d n=%0d: addr=%h rot=%0d tw=%h required addr=%h rot=%0d tw=%h",
                        m, n, rd_addr8, rd_rot8, tw8, e_addr, e_rot, e_tw);
                end
                checks++;
                if ({wr_en8, wr_addr8, wr_rot8} !== {e_wen, e_waddr, e_wrot}) begin
                    errors++;
                    $display("FAIL wr8 m=%0d n=%0d: en=%b addr=%h rot=%0d required en=%b addr=%h rot=%0d",
                        m, n, wr_en8, wr_addr8, wr_rot8, e_wen, e_waddr, e_wrot);
                end
                if (rd_en8 === 1'b1) begin
                    for (int b = 0; b < 4; b++) begin
                        if (seen[b * 64 + int'(rd_addr8[b * 6 +: 6])]) dup++;
                        seen[b * 64 + int'(rd_addr8[b * 6 +: 6])] = 1'b1;
                    end
                end
                if (e_rd && off == Q8 - 1) begin
                    nset = $countones(seen);
                    checks++;
                    if (nset != 256 || dup != 0) begin
                        errors++;
                        $display("FAIL cover8 m=%0d stage=%0d: elements=%0d dups=%0d required 256/0", m, s, nset, dup);
                    end
                    seen = '0;
                    dup  = 0;
                end
            end
            mode8 = 1'b0;
        end
    endtask

    task automatic test_logn5();
        int idx, s, off, p, j;
        logic        e_rd, e_busy, e_done, e_r4;
        logic [3:0]  e_stage;
        logic [11:0] e_addr;
        logic [1:0]  e_rot;
        logic [4:0]  e_tw;
        @(posedge clk);
        #1;
        mode5  = 1'b0;
        start5 = 1'b1;
        for (int n = 1; n <= 3 * 14 + 3; n++) begin
            @(posedge clk);
            #1;
            start5 = 1'b0;
            idx    = n - 1;
            s      = idx / 14;
            off    = idx % 14;
            e_rd   = (s < 3) && (off < 8);
            e_busy = (n <= 42);
            e_done = (n == 43);
            e_stage = (n <= 42) ? 4'(s) : (e_done ? 4'd2 : 4'd0);
            p      = plan_p(5, 0, (s < 3) ? s : 2);
            e_r4   = e_busy && (p >= 0);
            e_addr = '0;
            e_rot  = '0;
            e_tw   = '0;
            if (e_rd) begin
                for (int k = 0; k < 4; k++) begin
                    j = elem(5, p, off, k);
                    e_addr[bankf(j) * 3 +: 3] = 3'(j / 4);
                end
                e_rot = 2'(bankf(elem(5, p, off, 0)));
                e_tw  = 5'(twf(5, p, off));
            end
            checks++;
            if ({rd_en5, busy5, done5, stage5, radix45} !== {e_rd, e_busy, e_done, e_stage, e_r4}) begin
                errors++;
                $display("FAIL ctl5 n=%0d: rd/busy/done/stage/r4=%b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                    n, rd_en5, busy5, done5, stage5, radix45, e_rd, e_busy, e_done, e_stage, e_r4);
            end
            checks++;
            if ({rd_addr5, rd_rot5, tw5} !== {e_addr, e_rot, e_tw}) begin
                errors++;
                $display("FAIL rd5 n=%0d: addr=%h rot=%0d tw=%h required addr=%h rot=%0d tw=%h",
                    n, rd_addr5, rd_rot5, tw5, e_addr, e_rot, e_tw);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int got = 0;
        @(posedge clk);
        #1;
        mode8  = 1'($urandom_range(0, 1));
        start8 = 1'b1;
        for (int n = 1; n <= 2 * L8 + 11; n++) begin
            @(posedge clk);
            #1;
            start8 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en8, rd_addr8, rd_rot8, wr_en8, wr_addr8, wr_rot8, tw8, radix48, stage8, busy8, done8} !== '0) begin
            errors++;
            $display("FAIL abort8: outputs=%h required all zero",
                {rd_en8, rd_addr8, rd_rot8, wr_en8, wr_addr8, wr_rot8, tw8, radix48, stage8, busy8, done8});
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold8 n=%0d: done=%b busy=%b required 0/0", n, done8, busy8);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mode8  = 1'b0;
        start8 = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            start8 = 1'b0;
            if (n == 1) begin
                checks++;
                if (rd_en8 !== 1'b1 || busy8 !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_first8: rd_en=%b busy=%b required 1/1", rd_en8, busy8);
                end
            end
            if (done8 === 1'b1 && got == 0) got = n;
        end
        checks++;
        if (got != S8 * L8 + 1) begin
            errors++;
            $display("FAIL restart_done8: done at cycle %0d required %0d", got, S8 * L8 + 1);
        end
    endtask

    task automatic test_start_held();
        logic [2:0] obs;
        @(posedge clk);
        #1;
        mode8  = 1'b0;
        start8 = 1'b1;
        for (int n = 1; n <= S8 * L8 + 3; n++) begin
            @(posedge clk);
            #1;
            obs = {done8, busy8, rd_en8};
            if (n == S8 * L8 + 1) begin
                checks++;
                if (obs !== 3'b100) begin
                    errors++;
                    $display("FAIL held_done8: done/busy/rd=%b required 100", obs);
                end
            end
            if (n == S8 * L8 + 2) begin
                checks++;
                if (obs !== 3'b000) begin
                    errors++;
                    $display("FAIL held_idle8: done/busy/rd=%b required 000", obs);
                end
            end
            if (n == S8 * L8 + 3) begin
                checks++;
                if (obs !== 3'b011 || stage8 !== 4'd0) begin
                    errors++;
                    $display("FAIL held_restart8: done/busy/rd=%b stage=%0d required 011/0", obs, stage8);
                end
            end
        end
        start8 = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_schedule8();
        test_logn5();
        test_reset_midrun();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
